// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch-side branch target buffer: direction state and entry layout.
// Tags are kept as a zero-extended word so the entry struct does not depend on ENTRIES.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } btb_state_t;

  typedef struct packed {
    logic       valid;
    word_t      tag;
    word_t      target;
    btb_state_t state;
  } btb_entry_t;

  // The upper state bit is the taken/not-taken decision in both predictor modes.
  function automatic logic state_taken(input btb_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/btb_dir_counter.sv
// Next-state logic for one direction predictor entry.
// BTB_TWO_BIT_EN selects the 2-bit saturating counter; otherwise a last-outcome bit held as WNT/WT.
module btb_dir_counter
  import cpu_types_pkg::*;
(
  input  btb_state_t state_i,
  input  logic       taken_i,
  output btb_state_t state_o
);

  // saturating counter step (or last-outcome bit) for the resolved branch
  always_comb begin
    state_o = state_i;
`ifdef BTB_TWO_BIT_EN
    case (state_i)
      SNT:     state_o = taken_i ? WNT : SNT;
      WNT:     state_o = taken_i ? WT  : SNT;
      WT:      state_o = taken_i ? ST  : WNT;
      ST:      state_o = taken_i ? ST  : WT;
      default: state_o = WNT;
    endcase
`else
    if (taken_i) begin
      state_o = WT;
    end else begin
      state_o = WNT;
    end
`endif
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: zero-latency IF lookup, EX-stage training, mispredict/redirect to hazard unit.
// Direction predictor width is selected by the BTB_TWO_BIT_EN macro (see btb_dir_counter).
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_pred_taken,
  input  logic [31:0] update_pred_target,
  input  logic        invalidate_all,
  output logic        mispredict,
  output logic [31:0] redirect_pc
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: 32'h0, target: 32'h0, state: WNT};

  btb_entry_t mem_q [ENTRIES];
  btb_entry_t mem_d [ENTRIES];

  logic [INDEX_W-1:0] lk_idx;
  word_t              lk_tag;
  btb_entry_t         lk_entry;
  logic               lk_hit;

  logic [INDEX_W-1:0] up_idx;
  word_t              up_tag;
  btb_entry_t         up_entry;
  logic               up_hit;
  btb_state_t         up_state_next;

  assign lk_idx   = lookup_pc[INDEX_W+1:2];
  assign lk_tag   = word_t'(lookup_pc >> (INDEX_W + 2));
  assign lk_entry = mem_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign up_idx   = update_pc[INDEX_W+1:2];
  assign up_tag   = word_t'(update_pc >> (INDEX_W + 2));
  assign up_entry = mem_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  btb_dir_counter u_dir_counter (
    .state_i (up_entry.state),
    .taken_i (update_taken),
    .state_o (up_state_next)
  );

  // IF-stage prediction reads the registered array only, so a same-cycle write is not seen
  always_comb begin
    predict_taken = lk_hit && state_taken(lk_entry.state);
    if (predict_taken) begin
      predict_target = lk_entry.target;
    end else begin
      predict_target = lookup_pc + 32'd4;
    end
  end

  // EX-stage resolution check against the prediction carried down the pipe
  always_comb begin
    mispredict = 1'b0;
    if (update_en) begin
      mispredict = (update_taken != update_pred_taken) ||
                   (update_taken && (update_pred_target != update_target));
    end else begin
      mispredict = 1'b0;
    end
    if (update_taken) begin
      redirect_pc = update_target;
    end else begin
      redirect_pc = update_pc + 32'd4;
    end
  end

  // training: invalidate has priority and drops any concurrent update
  always_comb begin
    mem_d = mem_q;
    if (invalidate_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_d[i].valid = 1'b0;
      end
    end else if (update_en) begin
      if (up_hit) begin
        mem_d[up_idx].state = up_state_next;
        if (update_taken) begin
          mem_d[up_idx].target = update_target;
        end else begin
          mem_d[up_idx].target = up_entry.target;
        end
      end else if (update_taken) begin
        mem_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: update_target, state: WT};
      end else begin
        mem_d[up_idx] = up_entry;
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // entry array register; async reset discards any in-flight write
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16), both predictor modes.
module tb_branch_target_buffer;

  logic        CLK;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        invalidate_all;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .lookup_pc          (lookup_pc),
    .predict_taken      (predict_taken),
    .predict_target     (predict_target),
    .update_en          (update_en),
    .update_pc          (update_pc),
    .update_taken       (update_taken),
    .update_target      (update_target),
    .update_pred_taken  (update_pred_taken),
    .update_pred_target (update_pred_target),
    .invalidate_all     (invalidate_all),
    .mispredict         (mispredict),
    .redirect_pc        (redirect_pc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One clocked update; inputs are applied on the falling edge and cleared one cycle later.
  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic inv);
    @(negedge CLK);
    update_en = 1'b1; update_pc = pc; update_taken = tk; update_target = tgt;
    update_pred_taken = 1'b0; update_pred_target = pc + 32'd4; invalidate_all = inv;
    @(negedge CLK);
    update_en = 1'b0; invalidate_all = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; update_en = 1'b0; update_pc = 32'h0; update_taken = 1'b0;
    update_target = 32'h0; update_pred_taken = 1'b0; update_pred_target = 32'h0;
    invalidate_all = 1'b0; lookup_pc = 32'h40;
    #2;
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_err++; $display("FAIL reset_lookup got %0b/%h want 0/00000044", predict_taken, predict_target);
    end
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_err++; $display("FAIL reset_mispredict got %0b want 0", mispredict);
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_allocate();
    @(negedge CLK);
    update_en = 1'b1; update_pc = 32'h40; update_taken = 1'b1; update_target = 32'h100;
    update_pred_taken = 1'b0; update_pred_target = 32'h44; lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h100) begin
      n_err++; $display("FAIL alloc_mispredict got %0b/%h want 1/00000100", mispredict, redirect_pc);
    end
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_err++; $display("FAIL alloc_no_bypass got %0b/%h want 0/00000044", predict_taken, predict_target);
    end
    @(negedge CLK);
    update_en = 1'b0;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
      n_err++; $display("FAIL alloc_lookup got %0b/%h want 1/00000100", predict_taken, predict_target);
    end
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_err++; $display("FAIL idle_mispredict got %0b want 0", mispredict);
    end
  endtask

  task automatic test_direction();
    logic [8:0] outcome;
    logic [8:0] exp_tk;
    logic [31:0] exp_tgt;
    outcome = 9'b001111000;   // bit i = outcome of step i
`ifdef BTB_TWO_BIT_EN
    exp_tk  = 9'b011110000;   // WNT,SNT,SNT,WNT,WT,ST,ST,WT,WNT
`else
    exp_tk  = 9'b001111000;   // last outcome
`endif
    for (int i = 0; i < 9; i++) begin
      do_update(32'h40, outcome[i], 32'h200, 1'b0);
      lookup_pc = 32'h40;
      #1;
      exp_tgt = exp_tk[i] ? 32'h200 : 32'h44;
      n_cmp++;
      if (predict_taken !== exp_tk[i] || predict_target !== exp_tgt) begin
        n_err++;
        $display("FAIL direction_step%0d got %0b/%h want %0b/%h", i, predict_taken,
                 predict_target, exp_tk[i], exp_tgt);
      end
    end
  endtask

  task automatic test_conflict();
    do_update(32'h40, 1'b1, 32'h100, 1'b0);
    lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
      n_err++; $display("FAIL conflict_first got %0b/%h want 1/00000100", predict_taken, predict_target);
    end
    do_update(32'h80, 1'b1, 32'h300, 1'b0);
    lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_err++; $display("FAIL conflict_evicted got %0b/%h want 0/00000044", predict_taken, predict_target);
    end
    lookup_pc = 32'h80;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h300) begin
      n_err++; $display("FAIL conflict_new got %0b/%h want 1/00000300", predict_taken, predict_target);
    end
    do_update(32'hC0, 1'b0, 32'h400, 1'b0);
    lookup_pc = 32'h80;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h300) begin
      n_err++; $display("FAIL miss_not_taken_kept got %0b/%h want 1/00000300", predict_taken, predict_target);
    end
  endtask

  task automatic test_invalidate();
    do_update(32'h40, 1'b1, 32'h500, 1'b1);
    lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_err++; $display("FAIL inval_drop got %0b/%h want 0/00000044", predict_taken, predict_target);
    end
    lookup_pc = 32'h80;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h84) begin
      n_err++; $display("FAIL inval_clear got %0b/%h want 0/00000084", predict_taken, predict_target);
    end
    do_update(32'h40, 1'b1, 32'h500, 1'b0);
    lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b1 || predict_target !== 32'h500) begin
      n_err++; $display("FAIL inval_realloc got %0b/%h want 1/00000500", predict_taken, predict_target);
    end
  endtask

  task automatic test_mispredict();
    @(negedge CLK);
    update_en = 1'b1; update_pc = 32'h1000; update_taken = 1'b1; update_target = 32'h600;
    update_pred_taken = 1'b1; update_pred_target = 32'h600;
    #1;
    n_cmp++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h600) begin
      n_err++; $display("FAIL correct_pred got %0b/%h want 0/00000600", mispredict, redirect_pc);
    end
    update_pred_target = 32'h604;
    #1;
    n_cmp++;
    if (mispredict !== 1'b1) begin
      n_err++; $display("FAIL wrong_target got %0b want 1", mispredict);
    end
    update_taken = 1'b0; update_pred_taken = 1'b0; update_pred_target = 32'h999;
    #1;
    n_cmp++;
    if (mispredict !== 1'b0 || redirect_pc !== 32'h1004) begin
      n_err++; $display("FAIL nt_correct got %0b/%h want 0/00001004", mispredict, redirect_pc);
    end
    update_en = 1'b0; update_taken = 1'b1; update_pred_taken = 1'b0;
    #1;
    n_cmp++;
    if (mispredict !== 1'b0) begin
      n_err++; $display("FAIL en_low got %0b want 0", mispredict);
    end
    update_taken = 1'b0; update_pc = 32'hFFFF_FFFC; lookup_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++;
    if (redirect_pc !== 32'h0 || predict_target !== 32'h0) begin
      n_err++; $display("FAIL wrap got %h/%h want 00000000/00000000", redirect_pc, predict_target);
    end
  endtask

  task automatic test_reset_mid_update();
    @(negedge CLK);
    update_en = 1'b1; update_pc = 32'h2000; update_taken = 1'b1; update_target = 32'h700;
    update_pred_taken = 1'b1; update_pred_target = 32'h700;
    #1;
    nRST = 1'b0;
    lookup_pc = 32'h40;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
      n_err++; $display("FAIL async_reset got %0b/%h want 0/00000044", predict_taken, predict_target);
    end
    @(negedge CLK);
    update_en = 1'b0;
    nRST = 1'b1;
    lookup_pc = 32'h2000;
    #1;
    n_cmp++;
    if (predict_taken !== 1'b0 || predict_target !== 32'h2004) begin
      n_err++; $display("FAIL reset_drop got %0b/%h want 0/00002004", predict_taken, predict_target);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_direction();
    test_conflict();
    test_invalidate();
    test_mispredict();
    test_reset_mid_update();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with per-entry direction predictor for the pipelined MIPS datapath. Predicts next fetch PC in IF (taken branch/jump target vs PC+4) and is trained from branch resolution in EX, removing the fixed penalty of resolving every branch in EX with no prediction. Generalises the current fixed fall-through fetch to a configurable-depth predictor that reports mispredicts and the corrected PC to the hazard unit.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 2..256
- INDEX_W, $clog2(ENTRIES), derived; index = pc[INDEX_W+1:2]; tag = pc[31:INDEX_W+2]

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- lookup_pc  in  32  IF-stage PC
- predict_taken  out  1  predicted taken
- predict_target  out  32  predicted next PC
- update_en  in  1  EX resolved a branch/jump; qualified by pipeline advance, not stall
- update_pc  in  32  PC of resolved instruction
- update_taken  in  1  actual outcome
- update_target  in  32  actual taken target
- update_pred_taken  in  1  prediction carried down the pipe with the instruction
- update_pred_target  in  32  prediction target carried down the pipe
- invalidate_all  in  1  clear all valid bits
- mispredict  out  1  flush request to hazard unit
- redirect_pc  out  32  corrected fetch PC

## Operation
- Entry: valid, tag, 32-bit target, direction state.
- Direction states (2-bit): SNT=00, WNT=01, WT=10, ST=11; predict taken iff state[1].
- Lookup (combinational from registered array): hit = valid & tag match. predict_taken = hit & taken-state; predict_target = predict_taken ? entry.target : lookup_pc + 4 (32-bit wrap).
- Update on update_en, tag hit: state saturating increment if taken, decrement if not (ST+taken stays ST, SNT+not-taken stays SNT); target overwritten only when taken.
- Update on update_en, miss: taken -> allocate (valid=1, tag, target, state=WT), evicting occupant; not-taken -> no change.
- mispredict = update_en & ((update_taken != update_pred_taken) | (update_taken & update_pred_target != update_target)).
- redirect_pc = update_taken ? update_target : update_pc + 4.
- invalidate_all: all valid=0 at next edge; states/targets untouched.

## Timing
- Lookup: zero latency, same cycle as lookup_pc.
- Update: written at rising edge with update_en; visible to lookup next cycle. Same-cycle lookup of the updated index returns old contents (no bypass).
- mispredict/redirect_pc: combinational from update inputs, same cycle; hazard unit flushes IF/ID and ID/EX.
- invalidate_all and update_en same cycle: invalidate wins; the update is dropped.
- Reset (async, immediate): all valid=0, states=WNT, targets=0. Outputs during/after reset: predict_taken=0, predict_target=lookup_pc+4; mispredict=0 unless update_en asserted. Reset mid-update discards the write.
- update_en=0: array unchanged, mispredict=0.

## Configuration
- BTB_TWO_BIT_EN defined: 2-bit saturating state as above.
- Undefined: 1-bit last-outcome state; predict taken iff bit=1; update sets bit=update_taken; allocation sets bit=1; reset bit=0. Tag/target/mispredict logic identical.

## Structure
- cpu_types_pkg: btb_state_t enum (SNT, WNT, WT, ST), btb_entry_t packed struct (valid, tag, target, state); tag width via module parameter, so struct parametrised locally or tag stored as word_t masked.
- One sub-module: btb_dir_counter (combinational next-state for saturating counter, honouring BTB_TWO_BIT_EN).

## Test plan
- Reset, lookup_pc=0x40 -> predict_taken=0, predict_target=0x44.
- Update 0x40 taken target 0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100; next cycle lookup 0x40 -> taken, 0x100.
- Same entry then two not-taken updates -> state WT->WNT->SNT; lookup 0x40 -> not taken, 0x44; third not-taken stays SNT.
- ENTRIES=16: allocate 0x40 taken, then 0x80 taken (same index, different tag) -> lookup 0x40 misses, 0x80 hits.
- invalidate_all with simultaneous taken update of 0x40 -> next cycle lookup 0x40 not taken; update dropped.
- Correct prediction (pred_taken=1, target match) -> mispredict=0; taken with wrong pred_target -> mispredict=1.
